// File: rtl/dot4_accum_if.sv
// Handshake bundle for dot4_accum: operand stream in, dot-product result out.
// The master side is the producer/consumer around the block; the slave side is the block itself.
interface dot4_accum_if #(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/dot4_accum.sv
// Streaming 4-bit x 4-bit multiply-accumulate that emits one N_TERMS-term dot product
// per result, holding it (with a wrap indicator) until the consumer takes it.
module dot4_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    dot4_accum_if.slave  io_bus
);
    localparam int CNT_W = $clog2(N_TERMS);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_wrap;
    logic [ACC_W-1:0]   r_sum;
    logic               r_ovf;

    logic [7:0]         w_prod8;
    logic [ACC_W-1:0]   w_product;
    logic [ACC_W:0]     w_addFull;
    logic               w_carry;
    logic               w_xfer;
    logic               w_lastTerm;

    assign w_prod8    = {4'b0000, io_bus.a} * {4'b0000, io_bus.b};
    assign w_product  = ACC_W'(w_prod8);
    assign w_addFull  = {1'b0, r_acc} + {1'b0, w_product};
    assign w_carry    = w_addFull[ACC_W];
    assign w_xfer     = io_bus.in_valid & io_bus.in_ready;
    assign w_lastTerm = (r_count == CNT_W'(N_TERMS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Handshake outputs depend only on the registered state, so out_ready never reaches in_ready combinationally.
    always_comb begin
        w_nextState      = r_state;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        case (r_state)
            ACC: begin
                io_bus.in_ready = 1'b1;
                if (!clr && w_xfer && w_lastTerm) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_nextState = ACC;
                end
            end
            default: begin
                w_nextState = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (clr) begin
                        r_acc   <= '0;
                        r_count <= '0;
                        r_wrap  <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_lastTerm) begin
                            r_sum   <= w_addFull[ACC_W-1:0];
                            r_ovf   <= r_wrap | w_carry;
                            r_acc   <= '0;
                            r_count <= '0;
                            r_wrap  <= 1'b0;
                        end else begin
                            r_acc   <= w_addFull[ACC_W-1:0];
                            r_count <= r_count + CNT_W'(1);
                            r_wrap  <= r_wrap | w_carry;
                        end
                    end
                end
                DONE: begin
                    // clr is deliberately ignored here so a presented result cannot be lost.
                    if (io_bus.out_ready) begin
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.sum = r_sum;
    assign io_bus.ovf = r_ovf;
endmodule

// File: tb/tb_dot4_accum.sv
// Drives a 12-bit and an 8-bit accumulator with identical streams and checks both
// against a dot-product model computed from the true (unbounded) sum of the accepted pairs.
module tb_dot4_accum;
    localparam int N_TERMS = 4;
    localparam int WA      = 12;
    localparam int WB      = 8;

    logic clk;
    logic rst;
    logic clr;

    int compared   = 0;
    int mismatched = 0;
    int products[$];

    dot4_accum_if #(.ACC_W(WA)) busA ();
    dot4_accum_if #(.ACC_W(WB)) busB ();

    dot4_accum #(.N_TERMS(N_TERMS), .ACC_W(WA)) dutA (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .io_bus (busA.slave)
    );

    dot4_accum #(.N_TERMS(N_TERMS), .ACC_W(WB)) dutB (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .io_bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIn(input logic v, input logic [3:0] a, input logic [3:0] b);
        busA.in_valid = v;
        busB.in_valid = v;
        busA.a = a;
        busB.a = a;
        busA.b = b;
        busB.b = b;
    endtask

    task automatic driveOutReady(input logic r);
        busA.out_ready = r;
        busB.out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int modelSum();
        int s = 0;
        foreach (products[i]) s += products[i];
        return s;
    endfunction

    // One operand pair after `gap` idle cycles; waits (bounded) for in_ready before transferring.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int gap);
        int waitCnt;
        driveIn(1'b0, 4'd0, 4'd0);
        repeat (gap) stepClk();
        driveIn(1'b1, a, b);
        waitCnt = 0;
        while (!(busA.in_ready === 1'b1 && busB.in_ready === 1'b1) && waitCnt < 20) begin
            stepClk();
            waitCnt++;
        end
        if (waitCnt >= 20) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL inReadyTimeout observed=0 expected=1");
        end
        stepClk();
        products.push_back(int'(a) * int'(b));
        driveIn(1'b0, 4'd0, 4'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".validA"}, busA.out_valid, 1'b0);
        checkOutput({tag, ".validB"}, busB.out_valid, 1'b0);
        checkOutput({tag, ".readyA"}, busA.in_ready, 1'b1);
        checkOutput({tag, ".readyB"}, busB.in_ready, 1'b1);
    endtask

    task automatic checkResult(input string tag, input int trueSum);
        checkOutput({tag, ".validA"}, busA.out_valid, 1'b1);
        checkOutput({tag, ".validB"}, busB.out_valid, 1'b1);
        checkOutput({tag, ".readyA"}, busA.in_ready, 1'b0);
        checkOutput({tag, ".readyB"}, busB.in_ready, 1'b0);
        checkOutput({tag, ".sumA"}, busA.sum, trueSum % (1 << WA));
        checkOutput({tag, ".ovfA"}, busA.ovf, trueSum >= (1 << WA));
        checkOutput({tag, ".sumB"}, busB.sum, trueSum % (1 << WB));
        checkOutput({tag, ".ovfB"}, busB.ovf, trueSum >= (1 << WB));
    endtask

    task automatic checkResetState(input string tag);
        checkIdle(tag);
        checkOutput({tag, ".sumA"}, busA.sum, 0);
        checkOutput({tag, ".sumB"}, busB.sum, 0);
        checkOutput({tag, ".ovfA"}, busA.ovf, 1'b0);
        checkOutput({tag, ".ovfB"}, busB.ovf, 1'b0);
    endtask

    task automatic acceptResult(input string tag);
        driveOutReady(1'b1);
        stepClk();
        driveOutReady(1'b0);
        checkIdle({tag, ".after"});
        checkOutput({tag, ".ovfClrB"}, busB.ovf, 1'b0);
        products.delete();
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        driveIn(1'b0, 4'd0, 4'd0);
        driveOutReady(1'b0);
        repeat (2) stepClk();
        rst = 1'b0;
        checkResetState("reset");

        // Back-to-back pairs with the consumer always ready: a single one-cycle result pulse.
        driveOutReady(1'b1);
        applyStimulus(4'd15, 4'd12, 0);
        applyStimulus(4'd11, 4'd13, 0);
        applyStimulus(4'd9, 4'd14, 0);
        checkIdle("basic.latency");
        applyStimulus(4'd7, 4'd11, 0);
        checkResult("basic", 526);
        stepClk();
        driveOutReady(1'b0);
        checkIdle("basic.pulse");
        products.delete();

        // Backpressure: result held for 5 cycles while a new pair and clr are presented.
        applyStimulus(4'd15, 4'd12, 0);
        applyStimulus(4'd11, 4'd13, 0);
        applyStimulus(4'd9, 4'd14, 0);
        applyStimulus(4'd7, 4'd11, 0);
        products.delete();
        driveIn(1'b1, 4'd2, 4'd2);
        for (int i = 0; i < 5; i++) begin
            clr = (i == 2);
            checkResult($sformatf("hold%0d", i), 526);
            stepClk();
        end
        clr = 1'b0;
        checkResult("hold5", 526);
        driveOutReady(1'b1);
        stepClk();
        driveOutReady(1'b0);
        checkIdle("release");
        stepClk();
        products.push_back(4);
        driveIn(1'b0, 4'd0, 4'd0);
        applyStimulus(4'd1, 4'd1, 0);
        applyStimulus(4'd1, 4'd1, 0);
        applyStimulus(4'd1, 4'd1, 0);
        checkResult("afterHold", 7);
        acceptResult("afterHold");

        // Abort: clr discards the partial sum and the pair offered in the same cycle.
        applyStimulus(4'd15, 4'd15, 0);
        applyStimulus(4'd15, 4'd15, 0);
        clr = 1'b1;
        driveIn(1'b1, 4'd7, 4'd7);
        stepClk();
        clr = 1'b0;
        driveIn(1'b0, 4'd0, 4'd0);
        products.delete();
        checkIdle("abort");
        for (int i = 0; i < 4; i++) applyStimulus(4'd1, 4'd1, 0);
        checkResult("abort", 4);
        acceptResult("abort");

        // Wrap detection, seen only by the 8-bit instance.
        applyStimulus(4'd15, 4'd15, 0);
        applyStimulus(4'd1, 4'd1, 0);
        applyStimulus(4'd0, 4'd0, 0);
        applyStimulus(4'd0, 4'd0, 0);
        checkResult("noWrap", 226);
        acceptResult("noWrap");
        applyStimulus(4'd15, 4'd15, 0);
        applyStimulus(4'd15, 4'd15, 0);
        applyStimulus(4'd0, 4'd0, 0);
        applyStimulus(4'd0, 4'd0, 0);
        checkResult("wrap", 450);
        acceptResult("wrap");

        // Reset mid-accumulation beats clr and a concurrent transfer.
        applyStimulus(4'd9, 4'd9, 0);
        applyStimulus(4'd8, 4'd8, 0);
        rst = 1'b1;
        clr = 1'b1;
        driveIn(1'b1, 4'd5, 4'd5);
        stepClk();
        rst = 1'b0;
        clr = 1'b0;
        driveIn(1'b0, 4'd0, 4'd0);
        products.delete();
        checkResetState("rstMid");
        for (int i = 0; i < 4; i++) applyStimulus(4'd2, 4'd3, 0);
        checkResult("rstMid", 24);

        // Reset while a result is presented discards it.
        rst = 1'b1;
        driveOutReady(1'b1);
        stepClk();
        rst = 1'b0;
        driveOutReady(1'b0);
        products.delete();
        checkResetState("rstDone");

        // Random pairs, idle gaps and consumer delays over 100 results.
        for (int r = 0; r < 100; r++) begin
            for (int t = 0; t < N_TERMS; t++) begin
                applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), int'($urandom_range(3)));
            end
            checkResult($sformatf("rand%0d", r), modelSum());
            repeat ($urandom_range(2)) stepClk();
            checkResult($sformatf("rand%0d.held", r), modelSum());
            acceptResult($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dot4_accum.md
DOT4_ACCUM -- requirements
Module: dot4_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 4: number of products summed per result, legal range 2..16.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator and result width, legal range 8..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous abort of the current accumulation.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair on a/b is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-008 SHALL have port a, input, 4 bits: unsigned multiplicand.
REQ-009 SHALL have port b, input, 4 bits: unsigned multiplier.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port sum, output, ACC_W bits: dot-product result.
REQ-013 SHALL have port ovf, output, 1 bit: the accumulation of the presented result wrapped.

Function
REQ-014 SHALL compute product = a*b as an 8-bit unsigned value, combinationally, zero-extended to ACC_W.
REQ-015 SHALL implement two states: ACC (collecting products) and DONE (holding the result).
REQ-016 SHALL drive in_ready=1 in ACC and in_ready=0 in DONE; out_valid SHALL equal (state==DONE).
REQ-017 SHALL treat an input transfer as in_valid&in_ready in the same cycle; no other cycle may change acc or count.
REQ-018 On a transfer in ACC with count<N_TERMS-1, SHALL do acc<=acc+product (mod 2^ACC_W) and count<=count+1.
REQ-019 On a transfer in ACC with count==N_TERMS-1, SHALL load sum<=acc+product, clear acc and count, and enter DONE; out_valid SHALL assert the next cycle, giving 1-cycle latency from the last transfer.
REQ-020 SHALL set an internal wrap flag when any addition for the current result carries out of ACC_W bits; ovf SHALL show that flag while in DONE and SHALL read 0 in ACC.
REQ-021 In DONE, sum and ovf SHALL hold stable until out_valid&out_ready.
REQ-022 On out_valid&out_ready, SHALL return to ACC; the wrap flag SHALL clear and in_ready SHALL assert the next cycle, with no combinational path from out_ready to in_ready.
REQ-023 clr=1 in ACC SHALL zero acc, count and the wrap flag and ignore any concurrent transfer.
REQ-024 clr=1 in DONE SHALL have no effect, so a presented result is never dropped.
REQ-025 in_valid held low SHALL stall the accumulation indefinitely without changing state; gaps between transfers SHALL be legal.
REQ-026 count SHALL be ceil(log2(N_TERMS)) bits wide and SHALL never exceed N_TERMS-1.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=ACC, acc=0, count=0, wrap flag=0, sum=0, ovf=0, out_valid=0, in_ready=1.
REQ-028 rst SHALL take priority over clr, transfers and out_ready, including mid-accumulation and in DONE, and any partial or presented result SHALL be discarded.

Verification
REQ-029 SHALL verify basic operation: with N_TERMS=4, send pairs (15,12),(11,13),(9,14),(7,11) back-to-back with out_ready=1 -> exactly one out_valid pulse with sum=526, ovf=0, one cycle after the 4th transfer.
REQ-030 SHALL verify backpressure: same stimulus with out_ready=0 for 5 cycles -> sum=526 held, in_ready=0 throughout, next pair accepted only in the cycle after out_ready=1.
REQ-031 SHALL verify abort: send (15,15),(15,15), assert clr, then send four pairs of (1,1) -> sum=4, with no trace of the aborted 450.
REQ-032 SHALL verify overflow: with ACC_W=8, send (15,15),(1,1),(0,0),(0,0) -> sum=226, ovf=0; then send (15,15),(15,15),(0,0),(0,0) -> sum=194 (450 mod 256), ovf=1.
REQ-033 SHALL verify reset mid-operation: assert rst after 2 transfers, then send (2,3),(2,3),(2,3),(2,3) -> sum=24.
REQ-034 SHALL verify gaps: randomise in_valid gaps of 0-3 cycles over 100 results -> each sum matches the reference-model dot product and no transfer is lost or duplicated.
